// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed 7-segment display: synchronizes an/seg and rebuilds
// the four displayed hex digits, debounced over several scans, with illegal-pattern flagging.

module seven_seg_capture_digit #(
    parameter int STABLE_SCANS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cap_en,
    input  logic       cap_ok,
    input  logic       cap_blank,
    input  logic [3:0] cap_nib,
    output logic [3:0] nib,
    output logic       blank,
    output logic       valid,
    output logic       chg
);
    localparam int MW = $clog2(STABLE_SCANS + 1);

    logic [MW-1:0] mcnt, next_cnt;
    logic          cand_blank, same;
    logic [3:0]    cand_nib, conf_nib;

    always_comb begin
        same     = (mcnt != '0) && (cand_blank == cap_blank) && (cand_nib == cap_nib);
        next_cnt = MW'(1);
        if (same) next_cnt = (mcnt == MW'(STABLE_SCANS)) ? mcnt : mcnt + MW'(1);
        conf_nib = cap_blank ? 4'h0 : cap_nib;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcnt       <= '0;
            cand_blank <= 1'b0;
            cand_nib   <= 4'h0;
            nib        <= 4'h0;
            blank      <= 1'b0;
            valid      <= 1'b0;
            chg        <= 1'b0;
        end else begin
            chg <= 1'b0;
            if (cap_en) begin
                if (!cap_ok) begin
                    // illegal capture only breaks the match streak
                    mcnt <= '0;
                end else begin
                    cand_blank <= cap_blank;
                    cand_nib   <= cap_nib;
                    mcnt       <= next_cnt;
                    if (next_cnt == MW'(STABLE_SCANS)) begin
                        nib   <= conf_nib;
                        blank <= cap_blank;
                        valid <= 1'b1;
                        chg   <= !valid || (nib != conf_nib) || (blank != cap_blank);
                    end
                end
            end
        end
    end
endmodule

module seven_seg_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_SCANS   = 2,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic        all_valid,
    output logic [3:0]  blank,
    output logic        pattern_err,
    output logic        update,
    output logic        scan_active
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    logic [3:0]      an_s1, an_s2, cur_an;
    logic [6:0]      seg_s1, seg_s2;
    logic            an_legal, capture;
    logic [1:0]      cur_idx;
    logic [5:0]      dec;
    logic [SW-1:0]   cnt;
    logic [TW-1:0]   to_cnt;
    logic [3:0]      chg;
    logic [3:0][3:0] nibs;
    state_t          state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_s1  <= 4'h0;
            an_s2  <= 4'h0;
            seg_s1 <= 7'h0;
            seg_s2 <= 7'h0;
        end else begin
            an_s1  <= an;
            an_s2  <= an_s1;
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
        end
    end

    always_comb begin
        an_legal = 1'b1;
        cur_idx  = 2'd0;
        case (an_s2)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_legal = 1'b1;
            default:                            an_legal = 1'b0;
        endcase
        case (cur_an)
            4'b1101: cur_idx = 2'd1;
            4'b1011: cur_idx = 2'd2;
            4'b0111: cur_idx = 2'd3;
            default: cur_idx = 2'd0;
        endcase
    end

    // an anode change on the completing cycle takes priority over the capture
    assign capture = (state == SETTLE) && an_legal && (an_s2 == cur_an) &&
                     (cnt == SW'(SETTLE_CYCLES));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cur_an <= 4'hF;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (an_legal) begin
                    cur_an <= an_s2;
                    cnt    <= SW'(1);
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (!an_legal) state <= IDLE;
                    else if (an_s2 != cur_an) begin
                        cur_an <= an_s2;
                        cnt    <= SW'(1);
                    end else if (cnt == SW'(SETTLE_CYCLES)) state <= CAPTURED;
                    else cnt <= cnt + SW'(1);
                end
                CAPTURED: begin
                    if (!an_legal) state <= IDLE;
                    else if (an_s2 != cur_an) begin
                        cur_an <= an_s2;
                        cnt    <= SW'(1);
                        state  <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // active-low pattern -> {legal, blank, nibble}
    always_comb begin
        case (seg_s2)
            7'h40: dec = 6'b10_0000;  7'h79: dec = 6'b10_0001;
            7'h24: dec = 6'b10_0010;  7'h30: dec = 6'b10_0011;
            7'h19: dec = 6'b10_0100;  7'h12: dec = 6'b10_0101;
            7'h02: dec = 6'b10_0110;  7'h78: dec = 6'b10_0111;
            7'h00: dec = 6'b10_1000;  7'h10: dec = 6'b10_1001;
            7'h08: dec = 6'b10_1010;  7'h03: dec = 6'b10_1011;
            7'h46: dec = 6'b10_1100;  7'h21: dec = 6'b10_1101;
            7'h06: dec = 6'b10_1110;  7'h0E: dec = 6'b10_1111;
            7'h7F: dec = 6'b11_0000;
            default: dec = 6'b00_0000;
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_digit
        seven_seg_capture_digit #(.STABLE_SCANS(STABLE_SCANS)) u_digit (
            .clock     (clock),
            .reset     (reset),
            .cap_en    (capture && (cur_idx == 2'(i))),
            .cap_ok    (dec[5]),
            .cap_blank (dec[4]),
            .cap_nib   (dec[3:0]),
            .nib       (nibs[i]),
            .blank     (blank[i]),
            .valid     (digit_valid[i]),
            .chg       (chg[i])
        );
    end

    assign value     = nibs;
    assign all_valid = &digit_valid;
    assign update    = |chg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pattern_err <= 1'b0;
            scan_active <= 1'b0;
            to_cnt      <= '0;
        end else begin
            if (capture && !dec[5]) pattern_err <= 1'b1;
            if (capture) begin
                to_cnt      <= TW'(TIMEOUT_CYCLES);
                scan_active <= 1'b1;
            end else if (to_cnt != '0) begin
                to_cnt <= to_cnt - TW'(1);
                if (to_cnt == TW'(1)) scan_active <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans hand-built digit patterns and checks
// reconstructed value, flags, update pulses and scan timeout.

module tb_seven_seg_capture;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] value;
    logic [3:0]  digit_valid, blank;
    logic        all_valid, pattern_err, update, scan_active;

    int total = 0, bad = 0;
    int upd_cnt = 0, falls = 0, upd_base = 0, fall_base = 0;
    logic prev_sa = 1'b0;

    seven_seg_capture #(.SETTLE_CYCLES(4), .STABLE_SCANS(2), .TIMEOUT_CYCLES(200)) dut (
        .clock(clock), .reset(reset), .an(an), .seg(seg), .value(value),
        .digit_valid(digit_valid), .all_valid(all_valid), .blank(blank),
        .pattern_err(pattern_err), .update(update), .scan_active(scan_active)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (update === 1'b1) upd_cnt++;
        if (prev_sa === 1'b1 && scan_active === 1'b0) falls++;
        prev_sa = scan_active;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a;
        seg = s;
        hold(n);
    endtask

    task automatic scan4(input logic [6:0] d3, input logic [6:0] d2,
                         input logic [6:0] d1, input logic [6:0] d0);
        show(4'b1110, d0, 10);
        show(4'b1101, d1, 10);
        show(4'b1011, d2, 10);
        show(4'b0111, d3, 10);
    endtask

    initial begin
        hold(3);
        check("rst_value", 32'(value), 32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_all_valid", 32'(all_valid), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        check("rst_pattern_err", 32'(pattern_err), 32'h0);
        check("rst_update", 32'(update), 32'h0);
        check("rst_scan_active", 32'(scan_active), 32'h0);
        reset = 1'b1;
        hold(2);

        // glitch 40->79 inside the settle window: only 79 is captured, once
        upd_base = upd_cnt;
        an = 4'b1110; seg = 7'h40;
        hold(3);
        seg = 7'h79;
        hold(17);
        check("glitch_single_capture", 32'(digit_valid), 32'h0);
        show(4'b1111, 7'h7F, 6);
        show(4'b1110, 7'h79, 12);
        check("glitch_value", 32'(value), 32'h0001);
        check("glitch_valid", 32'(digit_valid), 32'h1);
        check("glitch_updates", 32'(upd_cnt - upd_base), 32'd1);

        // scan 1234 three times
        upd_base = upd_cnt;
        repeat (3) scan4(7'h79, 7'h24, 7'h30, 7'h19);
        check("scan_value", 32'(value), 32'h1234);
        check("scan_all_valid", 32'(all_valid), 32'h1);
        check("scan_updates", 32'(upd_cnt - upd_base), 32'd4);
        check("scan_pattern_err", 32'(pattern_err), 32'h0);
        check("scan_blank", 32'(blank), 32'h0);
        check("scan_active_on", 32'(scan_active), 32'h1);

        // digit 0 alternating E/F never confirms, then steady F confirms once
        upd_base = upd_cnt;
        for (int k = 0; k < 5; k++) begin
            show(4'b1111, 7'h7F, 4);
            show(4'b1110, (k % 2 == 0) ? 7'h06 : 7'h0E, 10);
        end
        check("alt_no_update", 32'(upd_cnt - upd_base), 32'd0);
        check("alt_value", 32'(value), 32'h1234);
        show(4'b1111, 7'h7F, 4);
        show(4'b1110, 7'h0E, 10);
        check("steady_first_no_update", 32'(upd_cnt - upd_base), 32'd0);
        show(4'b1111, 7'h7F, 4);
        show(4'b1110, 7'h0E, 10);
        check("steady_value", 32'(value), 32'h123F);
        check("steady_updates", 32'(upd_cnt - upd_base), 32'd1);

        // illegal pattern on digit 2, blank on digit 3
        show(4'b1011, 7'h55, 10);
        check("illegal_err", 32'(pattern_err), 32'h1);
        check("illegal_value", 32'(value), 32'h123F);
        show(4'b0111, 7'h7F, 10);
        show(4'b1111, 7'h7F, 4);
        show(4'b0111, 7'h7F, 10);
        check("blank_bits", 32'(blank), 32'h8);
        check("blank_value", 32'(value), 32'h023F);
        check("err_sticky", 32'(pattern_err), 32'h1);

        // illegal anodes: no captures, then scan timeout
        upd_base = upd_cnt;
        fall_base = falls;
        show(4'b1111, 7'h79, 60);
        check("idle_still_active", 32'(scan_active), 32'h1);
        show(4'b1100, 7'h79, 300);
        check("timeout_inactive", 32'(scan_active), 32'h0);
        check("timeout_one_fall", 32'(falls - fall_base), 32'd1);
        check("idle_no_update", 32'(upd_cnt - upd_base), 32'd0);
        check("idle_value", 32'(value), 32'h023F);

        // ABCD, then reset mid-settle and rescan
        repeat (2) scan4(7'h08, 7'h03, 7'h46, 7'h21);
        check("abcd_value", 32'(value), 32'hABCD);
        check("abcd_blank", 32'(blank), 32'h0);
        show(4'b1110, 7'h21, 4);
        reset = 1'b0;
        #1;
        check("mid_rst_value", 32'(value), 32'h0);
        check("mid_rst_valid", 32'(digit_valid), 32'h0);
        check("mid_rst_err", 32'(pattern_err), 32'h0);
        check("mid_rst_active", 32'(scan_active), 32'h0);
        hold(2);
        reset = 1'b1;
        hold(1);
        upd_base = upd_cnt;
        repeat (2) scan4(7'h08, 7'h03, 7'h46, 7'h21);
        check("rescan_value", 32'(value), 32'hABCD);
        check("rescan_all_valid", 32'(all_valid), 32'h1);
        check("rescan_updates", 32'(upd_cnt - upd_base), 32'd4);
        check("rescan_err", 32'(pattern_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
